// File: rtl/instr_encoder.sv
// Packs mnemonic + fields into 32-bit MIPS words and streams them to sequential IM word addresses.
// Optional feature macro: ENC_NEWOP_EN (op 11 encodes {6'h3F,rs,rt,imm}; otherwise op 11 is illegal).
module instr_encoder #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned BASE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_tgt,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              err,
  output logic [ADDR_W:0]   count,
  output logic              full
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_ORI = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_SW  = 4'd4;
  localparam logic [3:0] OP_BEQ = 4'd5;
  localparam logic [3:0] OP_LUI = 4'd6;
  localparam logic [3:0] OP_JAL = 4'd7;
  localparam logic [3:0] OP_JR  = 4'd8;
  localparam logic [3:0] OP_J   = 4'd9;
  localparam logic [3:0] OP_NOP = 4'd10;
`ifdef ENC_NEWOP_EN
  localparam logic [3:0] OP_NEW = 4'd11;
`endif

  typedef enum logic {S_RUN, S_FULL} state_t;

  state_t             r_state;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [31:0]        r_wdata;
  logic               r_err;
  logic [CNT_W-1:0]   r_count;

  logic               w_ready;
  logic               w_accept;
  logic               w_legal;
  logic [31:0]        w_word;

  // Instruction encoding; unused fields are dropped and reserved bits forced to zero
  always_comb begin
    w_legal = 1'b1;
    w_word  = 32'h0000_0000;
    case (req_op)
      OP_ADD: w_word = {6'h00, req_rs, req_rt, req_rd, 5'h00, 6'h20};
      OP_SUB: w_word = {6'h00, req_rs, req_rt, req_rd, 5'h00, 6'h22};
      OP_ORI: w_word = {6'h0D, req_rs, req_rt, req_imm};
      OP_LW:  w_word = {6'h23, req_rs, req_rt, req_imm};
      OP_SW:  w_word = {6'h2B, req_rs, req_rt, req_imm};
      OP_BEQ: w_word = {6'h04, req_rs, req_rt, req_imm};
      OP_LUI: w_word = {6'h0F, 5'h00, req_rt, req_imm};
      OP_JAL: w_word = {6'h03, req_tgt};
      OP_JR:  w_word = {6'h00, req_rs, 15'h0000, 6'h08};
      OP_J:   w_word = {6'h02, req_tgt};
      OP_NOP: w_word = 32'h0000_0000;
`ifdef ENC_NEWOP_EN
      OP_NEW: w_word = {6'h3F, req_rs, req_rt, req_imm};
`endif
      default: w_legal = 1'b0;
    endcase
  end

  assign w_ready  = (r_state == S_RUN) && !start;
  assign w_accept = req_valid && w_ready;

  // Control FSM plus output registers; start has priority over any request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_RUN;
      r_we    <= 1'b0;
      r_addr  <= ADDR_W'(BASE);
      r_wdata <= 32'h0000_0000;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      r_we  <= 1'b0;
      r_err <= 1'b0;
      if (start) begin
        r_state <= S_RUN;
        r_count <= '0;
        r_addr  <= ADDR_W'(BASE);
      end else if (w_accept) begin
        if (w_legal) begin
          r_we    <= 1'b1;
          r_wdata <= w_word;
          r_addr  <= ADDR_W'(BASE) + ADDR_W'(r_count);
          r_count <= r_count + CNT_W'(1);
          if (r_count == CNT_W'(DEPTH - 1)) begin
            r_state <= S_FULL;
          end
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign req_ready = w_ready;
  assign im_we     = r_we;
  assign im_addr   = r_addr;
  assign im_wdata  = r_wdata;
  assign err       = r_err;
  assign count     = r_count;
  assign full      = (r_state == S_FULL);

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (DEPTH=4, BASE=16) with a queue scoreboard of expected IM writes.
module tb_instr_encoder;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned BASE   = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk;
  logic              reset;
  logic              start;
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [4:0]        req_rs;
  logic [4:0]        req_rt;
  logic [4:0]        req_rd;
  logic [15:0]       req_imm;
  logic [25:0]       req_tgt;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              err;
  logic [ADDR_W:0]   count;
  logic              full;

  int  checks;
  int  errors;
  int  m_count;
  bit  m_full;
  wr_t sb[$];

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk(clk), .reset(reset), .start(start),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_imm(req_imm), .req_tgt(req_tgt),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .err(err), .count(count), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, update the model, then check the registered outputs after the edge
  task automatic step(input logic v, input logic st, input logic [3:0] op,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [15:0] imm, input logic [25:0] tgt, input logic [31:0] exp_data);
    logic legal;
    logic acc;
    logic exp_rdy;
    logic exp_err;
    wr_t  w;
    req_valid = v; start = st; req_op = op;
    req_rs = rs; req_rt = rt; req_rd = rd; req_imm = imm; req_tgt = tgt;
    #1;
    exp_rdy = !m_full && !st;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
`ifdef ENC_NEWOP_EN
    legal = (op <= 4'd11);
`else
    legal = (op <= 4'd10);
`endif
    acc     = v && exp_rdy;
    exp_err = acc && !legal;
    if (acc && legal) begin
      w.addr = ADDR_W'(BASE + m_count);
      w.data = exp_data;
      sb.push_back(w);
      m_count++;
      m_full = (m_count == DEPTH);
    end
    if (st) begin
      m_count = 0;
      m_full  = 1'b0;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("im_we", 64'(im_we), 64'(sb.size() != 0));
    if (im_we === 1'b1 && sb.size() != 0) begin
      w = sb.pop_front();
      chk("im_addr", 64'(im_addr), 64'(w.addr));
      chk("im_wdata", 64'(im_wdata), 64'(w.data));
    end
    chk("err", 64'(err), 64'(exp_err));
    chk("count", 64'(count), 64'(m_count));
    chk("full", 64'(full), 64'(m_full));
  endtask

  task automatic chk_reset_state();
    chk("rst_we", 64'(im_we), 64'(0));
    chk("rst_addr", 64'(im_addr), 64'(BASE));
    chk("rst_wdata", 64'(im_wdata), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_full", 64'(full), 64'(0));
  endtask

  initial begin
    checks = 0; errors = 0; m_count = 0; m_full = 1'b0;
    reset = 1'b1; start = 1'b0; req_valid = 1'b0; req_op = 4'd0;
    req_rs = 5'd0; req_rt = 5'd0; req_rd = 5'd0; req_imm = 16'h0; req_tgt = 26'h0;
    #2;
    chk_reset_state();
    #10 reset = 1'b0;
    @(posedge clk);
    #1;

    // ORI rs=0 rt=1 imm=1234 lands at BASE
    step(1, 0, 4'd2, 5'd0, 5'd1, 5'd0, 16'h1234, 26'h0, 32'h3401_1234);
    // ADD then LUI back to back after a start; LUI ignores rs, ADD ignores imm/tgt
    step(0, 1, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 32'h0);
    step(1, 0, 4'd0, 5'd1, 5'd2, 5'd3, 16'hFFFF, 26'h3FF_FFFF, 32'h0022_1820);
    step(1, 0, 4'd6, 5'd5, 5'd2, 5'd7, 16'hABCD, 26'h0, 32'h3C02_ABCD);
    // JAL, JR, BEQ, SW fill the 4-deep window
    step(0, 1, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 32'h0);
    step(1, 0, 4'd7, 5'd9, 5'd9, 5'd9, 16'h5555, 26'h000_0C03, 32'h0C00_0C03);
    step(1, 0, 4'd8, 5'd31, 5'd4, 5'd6, 16'h7777, 26'h0, 32'h03E0_0008);
    step(1, 0, 4'd5, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 32'h1022_FFFF);
    step(1, 0, 4'd4, 5'd29, 5'd2, 5'd0, 16'h0004, 26'h0, 32'hAFA2_0004);
    // Full: request held off, no wrap
    step(1, 0, 4'd10, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 32'h0);
    step(1, 0, 4'd10, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 32'h0);
    // start with request in the same cycle: start wins
    step(1, 1, 4'd2, 5'd3, 5'd4, 5'd0, 16'h00FF, 26'h0, 32'h3464_00FF);
    step(1, 0, 4'd2, 5'd3, 5'd4, 5'd0, 16'h00FF, 26'h0, 32'h3464_00FF);
    // Five NOPs held valid: four writes, fifth held off
    step(0, 1, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 4'd10, 5'd1, 5'd2, 5'd3, 16'h1111, 26'h1, 32'h0000_0000);
    end
    step(0, 1, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 32'h0);
    // op 11 depends on build; op 13 always illegal
    step(1, 0, 4'd11, 5'd1, 5'd2, 5'd0, 16'h0005, 26'h0, 32'hFC22_0005);
    step(1, 0, 4'd13, 5'd1, 5'd2, 5'd3, 16'h0005, 26'h0, 32'h0);
    step(1, 0, 4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0022_1822);
    step(1, 0, 4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FF_FFFF, 32'h0BFF_FFFF);
    // start right after an accept: the in-flight write was already presented
    step(0, 1, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 32'h0);
    step(1, 0, 4'd3, 5'd4, 5'd5, 5'd0, 16'h0010, 26'h0, 32'h8C85_0010);
    step(0, 1, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 32'h0);
    // Reset asserted between edges while a write is in flight
    step(1, 0, 4'd2, 5'd0, 5'd1, 5'd0, 16'h1234, 26'h0, 32'h3401_1234);
    chk("inflight_we", 64'(im_we), 64'(1));
    reset = 1'b1;
    #1;
    chk_reset_state();
    #2 reset = 1'b0;
    sb.delete();
    m_count = 0;
    m_full  = 1'b0;
    step(1, 0, 4'd2, 5'd0, 5'd1, 5'd0, 16'h1234, 26'h0, 32'h3401_1234);
    step(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
